pulse_edge_timer: RTL and testbench
===================================

// Module: pulse_edge_timer
// PURPOSE
//  Front-end timing stage of the frequency counter. Synchronises the external test signal sig_in,
//  detects its edges and counts clk cycles in each high and low phase. Publishes high_time,
//  low_time and period_time with a one-cycle measurement_done strobe to the downstream
//  measurement processor, once per signal period, back-to-back.
// PARAMETERS
//  CNT_W          32        width of all time counters/outputs (clk cycles)
//  TIMEOUT_CYCLES 50000000  max cycles in any phase before abort (1 s @ 50 MHz); must be < 2^CNT_W
//  FILTER_LEN     4         stable cycles required by deglitch filter (used only with PET_DEGLITCH_EN)
// PORTS
//  clk              in   1      system clock
//  rst              in   1      asynchronous reset, active-high
//  sig_in           in   1      asynchronous signal under test
//  enable           in   1      1 = measure; 0 = abort and idle
//  high_time        out  CNT_W  clk cycles sig was high in last completed period
//  low_time         out  CNT_W  clk cycles sig was low in last completed period
//  period_time      out  CNT_W  high_time+low_time, saturating at all-ones
//  measurement_done out  1      1-cycle strobe: new values valid this cycle
//  busy             out  1      1 while in MEAS_HIGH/MEAS_LOW
//  timeout          out  1      sticky: a phase hit TIMEOUT_CYCLES; cleared on next measurement_done
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, sync/filter regs 0, counters 0. Reset mid-measurement discards it.
//  - sig_in -> 2-FF synchroniser -> (optional filter) -> s; edge detect on s vs s_d (1 cycle delayed).
//  - States: IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW; cnt = phase counter.
//    IDLE: enable=1 -> WAIT_RISE, cnt=0.
//    WAIT_RISE: wait for rise; on rise -> MEAS_HIGH, cnt=1. First partial period never reported.
//    MEAS_HIGH: cnt++ per cycle; on fall: hi_reg<=cnt, cnt<=1, -> MEAS_LOW.
//    MEAS_LOW: cnt++; on rise: high_time<=hi_reg, low_time<=cnt, period_time<=sat(hi_reg+cnt),
//      measurement_done<=1, timeout<=0, cnt<=1, -> MEAS_HIGH (closing rise opens next period).
//  - Latency: outputs and strobe appear 3 clk after the sig_in rise is first sampled (2 sync + 1 reg);
//    +FILTER_LEN with filter.
//  - Outputs hold between strobes; consecutive strobes are >=2 cycles apart (min 1 high + 1 low),
//    which the consumer's 1-cycle-later LOAD relies on.
//  - Timeout: in WAIT_RISE/MEAS_HIGH/MEAS_LOW, cnt==TIMEOUT_CYCLES -> timeout<=1, cnt<=0,
//    -> WAIT_RISE; no strobe, outputs hold.
//  - enable=0 in any state: next cycle -> IDLE, cnt/hi_reg cleared, no strobe, outputs/timeout hold.
//  - Edge coinciding with the timeout cycle: timeout wins, edge ignored.
//  - enable and rst do not affect the synchroniser except rst clears it.
// CONFIGURATION
//  PET_DEGLITCH_EN defined: s changes only after synced input differs from s for FILTER_LEN
//    consecutive cycles; pulses shorter than FILTER_LEN are dropped; widths preserved (delayed).
//  Not defined: s = synchroniser output; FILTER_LEN unused; no extra latency.
// TESTING
//  1 sig 40 high/60 low, enable=1 -> after first full period, done each 100 clk; 40/60/100.
//  2 TIMEOUT_CYCLES=1000, sig stuck high 1500 clk -> timeout=1 at 1000 clk after rise, no done;
//    next valid period clears timeout.
//  3 1 high/1 low toggling -> 1/1/2, done every 2 clk.
//  4 enable 1->0 mid-high -> busy=0, no done, outputs keep previous 40/60/100.
//  5 rst pulse mid-MEAS_LOW -> all outputs 0; first done only after a full new period.
//  6 PET_DEGLITCH_EN, FILTER_LEN=4: 2-clk low glitch inside 40-high -> ignored, 40/60/100 reported.

Source files
------------

// File: rtl/pulse_edge_timer.sv
// Synchronises sig_in, detects edges and measures high/low/period durations in clk cycles.
// Optional deglitch filter on the synchronised signal is enabled by defining PET_DEGLITCH_EN.
module pulse_edge_timer #(
  parameter int          CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int          FILTER_LEN     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] low_time,
  output logic [CNT_W-1:0] period_time,
  output logic             measurement_done,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  logic sync1_reg, sync2_reg, s_d_reg;
  logic s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      s_d_reg   <= 1'b0;
    end else begin
      sync1_reg <= sig_in;
      sync2_reg <= sync1_reg;
      s_d_reg   <= s;
    end
  end

`ifdef PET_DEGLITCH_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] flt_cnt_reg;
  logic          flt_reg;

  // Filtered level flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_cnt_reg <= '0;
      flt_reg     <= 1'b0;
    end else if (sync2_reg != flt_reg) begin
      if (flt_cnt_reg == FW'(FILTER_LEN - 1)) begin
        flt_reg     <= sync2_reg;
        flt_cnt_reg <= '0;
      end else begin
        flt_cnt_reg <= flt_cnt_reg + 1'b1;
      end
    end else begin
      flt_cnt_reg <= '0;
    end
  end

  assign s = flt_reg;
`else
  assign s = sync2_reg;
`endif

  logic rise, fall;
  assign rise = s & ~s_d_reg;
  assign fall = ~s & s_d_reg;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] hi_reg, hi_next;
  logic [CNT_W-1:0] high_next, low_next, period_next;
  logic             done_next, timeout_next;
  logic [CNT_W:0]   sum;

  assign sum  = {1'b0, hi_reg} + {1'b0, cnt_reg};
  assign busy = (state_reg == MEAS_HIGH) || (state_reg == MEAS_LOW);

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    high_next    = high_time;
    low_next     = low_time;
    period_next  = period_time;
    done_next    = 1'b0;
    timeout_next = timeout;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
      hi_next    = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = WAIT_RISE;
          cnt_next   = '0;
        end
        WAIT_RISE: begin
          if (cnt_reg == TIMEOUT_VAL) begin
            timeout_next = 1'b1;
            cnt_next     = '0;
          end else if (rise) begin
            state_next = MEAS_HIGH;
            cnt_next   = CNT_W'(1);
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (cnt_reg == TIMEOUT_VAL) begin
            timeout_next = 1'b1;
            cnt_next     = '0;
            state_next   = WAIT_RISE;
          end else if (fall) begin
            hi_next    = cnt_reg;
            cnt_next   = CNT_W'(1);
            state_next = MEAS_LOW;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        MEAS_LOW: begin
          if (cnt_reg == TIMEOUT_VAL) begin
            timeout_next = 1'b1;
            cnt_next     = '0;
            state_next   = WAIT_RISE;
          end else if (rise) begin
            // Closing rise publishes this period and immediately opens the next one.
            high_next    = hi_reg;
            low_next     = cnt_reg;
            period_next  = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            done_next    = 1'b1;
            timeout_next = 1'b0;
            cnt_next     = CNT_W'(1);
            state_next   = MEAS_HIGH;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      hi_reg           <= '0;
      high_time        <= '0;
      low_time         <= '0;
      period_time      <= '0;
      measurement_done <= 1'b0;
      timeout          <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      hi_reg           <= hi_next;
      high_time        <= high_next;
      low_time         <= low_next;
      period_time      <= period_next;
      measurement_done <= done_next;
      timeout          <= timeout_next;
    end
  end

endmodule

// File: tb/tb_pulse_edge_timer.sv
// Scoreboard bench for pulse_edge_timer: stimulus pushes expected periods, a monitor checks each strobe.
module tb_pulse_edge_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig_in;
  logic        enable;
  logic [31:0] high_time, low_time, period_time;
  logic        measurement_done, busy, timeout;

  pulse_edge_timer #(.CNT_W(32), .TIMEOUT_CYCLES(1000), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
    .high_time(high_time), .low_time(low_time), .period_time(period_time),
    .measurement_done(measurement_done), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int hi;
    int lo;
    int per;
    int gap;  // expected cycles since previous strobe, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   last_done_cyc = 0;
  int   n_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic push(input int hi, input int lo, input int gap);
    exp_t e;
    e.hi = hi; e.lo = lo; e.per = hi + lo; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic period(input int h, input int l);
    sig_in = 1'b1;
    repeat (h) @(negedge clk);
    sig_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && measurement_done) begin
      n_done++;
      $display("done #%0d @%0d: high=%0d low=%0d period=%0d timeout=%0d",
               n_done, cyc, high_time, low_time, period_time, timeout);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'b0, measurement_done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("high_time", high_time, e.hi);
        chk("low_time", low_time, e.lo);
        chk("period_time", period_time, e.per);
        chk("timeout_at_done", {31'b0, timeout}, 32'd0);
        if (e.gap != 0) chk("strobe_gap", cyc - last_done_cyc, e.gap);
      end
      last_done_cyc = cyc;
    end
  end

  initial begin
    rst = 1'b1; sig_in = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_high", high_time, 0);
    chk("rst_low", low_time, 0);
    chk("rst_period", period_time, 0);
    chk("rst_flags", {29'b0, measurement_done, busy, timeout}, 0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (5) @(negedge clk);

    // 40/60 periods: strobes 100 cycles apart
    push(40, 60, 0);   period(40, 60);
    push(40, 60, 100); period(40, 60);
    push(40, 60, 100); period(40, 60);
`ifdef PET_DEGLITCH_EN
    // 2-cycle low glitch inside the high phase must vanish
    push(40, 60, 100);
    period(15, 2); period(23, 60);
`else
    // fastest signal: 1 high / 1 low
    for (int i = 0; i < 4; i++) begin
      push(1, 1, 2);
      period(1, 1);
    end
`endif
    push(40, 60, 100); period(40, 60);

    // disable in the middle of a high phase
    sig_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("busy_before_disable", {31'b0, busy}, 1);
    enable = 1'b0; sig_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("disable_busy", {31'b0, busy}, 0);
    chk("disable_high", high_time, 40);
    chk("disable_low", low_time, 60);
    chk("disable_period", period_time, 100);
    repeat (5) @(negedge clk);

    // phase timeout with sig stuck high
    enable = 1'b1;
    repeat (5) @(negedge clk);
    sig_in = 1'b1;
    for (int k = 1; k <= 1500; k++) begin
      @(negedge clk);
      if (k == 10)   chk("to_busy_meas", {31'b0, busy}, 1);
      if (k == 1002) chk("to_not_yet", {31'b0, timeout}, 0);
      if (k == 1003) chk("to_set", {31'b0, timeout}, 1);
      if (k == 1004) chk("to_busy_idle", {31'b0, busy}, 0);
    end
    sig_in = 1'b0;
    repeat (50) @(negedge clk);
    push(30, 70, 0); period(30, 70);
    chk("to_sticky", {31'b0, timeout}, 1);
    sig_in = 1'b1;
    repeat (30) @(negedge clk);
    chk("to_cleared", {31'b0, timeout}, 0);

    // reset in the middle of a low phase
    sig_in = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_high", high_time, 0);
    chk("mid_rst_low", low_time, 0);
    chk("mid_rst_period", period_time, 0);
    chk("mid_rst_flags", {29'b0, measurement_done, busy, timeout}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    push(25, 75, 0); period(25, 75);
    sig_in = 1'b1;
    repeat (10) @(negedge clk);
    sig_in = 1'b0;
    repeat (20) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
